mem_sram_ctrl: RTL and testbench

Downstream stage of the AHB memory interpreter. Consumes its memory-side request (MEN/MWE/MADDR/MDIN) and returns MDONE/MERROR/MDOUT. Each 32-bit request is executed as one or two half-word cycles on an external asynchronous 16-bit SRAM, with programmable wait states and byte strobes. Sits between the interpreter and the board SRAM pins.

---
 rtl/mem_sram_pkg.sv | 20 ++
 rtl/mem_sram_wait_counter.sv | 29 ++
 rtl/mem_sram_ctrl.sv | 149 ++++++++++++++
 tb/tb_mem_sram_ctrl.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_sram_pkg.sv
// Shared types and constants for the 16-bit asynchronous SRAM controller.
package mem_sram_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD,
    DONE
  } state_t;

  localparam logic HALF_LO = 1'b0;
  localparam logic HALF_HI = 1'b1;

  localparam logic [3:0] LANES_LO = 4'b0011;
  localparam logic [3:0] LANES_HI = 4'b1100;

  localparam int unsigned WAIT_W = 4;

endpackage

// File: rtl/mem_sram_wait_counter.sv
// Loadable down-counter that times the strobe-low phase of each SRAM half access.
module mem_sram_wait_counter
  import mem_sram_pkg::*;
#(
  parameter int unsigned WIDTH = WAIT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_sram_ctrl.sv
// Executes 32-bit memory requests as one or two half-word cycles on an async 16-bit SRAM.
module mem_sram_ctrl
  import mem_sram_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH  = 32,
  parameter  int unsigned MEM_BYTES   = 1048576,
  parameter  int unsigned WAIT_CYCLES = 2,
  localparam int unsigned ADDR_WIDTH  = $clog2(MEM_BYTES) + 1,
  localparam int unsigned SADDR_WIDTH = $clog2(MEM_BYTES) - 1
) (
  input  logic                   MCLK,
  input  logic                   MRESETn,
  input  logic                   MEN,
  input  logic [3:0]             MWE,
  input  logic [ADDR_WIDTH-1:0]  MADDR,
  input  logic [DATA_WIDTH-1:0]  MDIN,
  output logic                   MDONE,
  output logic                   MERROR,
  output logic [DATA_WIDTH-1:0]  MDOUT,
  output logic [SADDR_WIDTH-1:0] SADDR,
  output logic [15:0]            SDQ_O,
  input  logic [15:0]            SDQ_I,
  output logic                   SDQ_OE,
  output logic                   SCE_N,
  output logic                   SOE_N,
  output logic                   SWE_N,
  output logic                   SLB_N,
  output logic                   SUB_N
);

  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(WAIT_CYCLES);

  state_t                   state_q, state_d;
  logic                     half_q;
  logic [3:0]               we_q;
  logic [ADDR_WIDTH-4:0]    waddr_q;
  logic [15:0]              din_hi_q;
  logic                     err_q;
  logic [DATA_WIDTH-1:0]    mdout_q;
  logic [SADDR_WIDTH-1:0]   saddr_q;
  logic [15:0]              sdq_o_q;

  logic is_write, req_err, first_half, more_halves, wait_zero, busy;
  logic unused_addr_bits;

  assign unused_addr_bits = ^MADDR[1:0];

  assign is_write    = |we_q;
  assign req_err     = MADDR[ADDR_WIDTH-1];
  // Writes skip a half whose byte enables are all clear; reads always start low.
  assign first_half  = (|MWE && ((MWE & LANES_LO) == 4'b0000)) ? HALF_HI : HALF_LO;
  assign more_halves = (half_q == HALF_LO) && (!is_write || |(we_q & LANES_HI));

  mem_sram_wait_counter #(
    .WIDTH(WAIT_W)
  ) u_wait (
    .clk     (MCLK),
    .rst_n   (MRESETn),
    .load    (state_q == SETUP),
    .load_val(WAIT_LOAD),
    .dec     (state_q == ACCESS),
    .zero    (wait_zero)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (MEN) state_d = req_err ? DONE : SETUP;
      SETUP:   state_d = ACCESS;
      ACCESS:  if (wait_zero) state_d = HOLD;
      HOLD:    state_d = more_halves ? SETUP : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_q == SETUP) || (state_q == ACCESS) || (state_q == HOLD);
    SCE_N  = ~busy;
    SDQ_OE = busy && is_write;
    SOE_N  = 1'b1;
    SWE_N  = 1'b1;
    SLB_N  = 1'b1;
    SUB_N  = 1'b1;
    if (state_q == ACCESS) begin
      if (is_write) begin
        SWE_N = 1'b0;
        SLB_N = ~we_q[{half_q, 1'b0}];
        SUB_N = ~we_q[{half_q, 1'b1}];
      end else begin
        SOE_N = 1'b0;
        SLB_N = 1'b0;
        SUB_N = 1'b0;
      end
    end
    MDONE  = (state_q == DONE);
    MERROR = (state_q == DONE) && err_q;
  end

  always_ff @(posedge MCLK) begin
    if (!MRESETn) begin
      state_q  <= IDLE;
      half_q   <= HALF_LO;
      we_q     <= '0;
      waddr_q  <= '0;
      din_hi_q <= '0;
      err_q    <= 1'b0;
      mdout_q  <= '0;
      saddr_q  <= '0;
      sdq_o_q  <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        IDLE: begin
          if (MEN) begin
            we_q     <= MWE;
            waddr_q  <= MADDR[ADDR_WIDTH-2:2];
            din_hi_q <= MDIN[31:16];
            err_q    <= req_err;
            if (!req_err) begin
              half_q  <= first_half;
              saddr_q <= {MADDR[ADDR_WIDTH-2:2], first_half};
              sdq_o_q <= first_half ? MDIN[31:16] : MDIN[15:0];
            end
          end
        end
        ACCESS: begin
          if (wait_zero && !is_write) begin
            if (half_q == HALF_HI) mdout_q[31:16] <= SDQ_I;
            else                   mdout_q[15:0]  <= SDQ_I;
          end
        end
        HOLD: begin
          if (more_halves) begin
            half_q  <= HALF_HI;
            saddr_q <= {waddr_q, HALF_HI};
            sdq_o_q <= din_hi_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign MDOUT = mdout_q;
  assign SADDR = saddr_q;
  assign SDQ_O = sdq_o_q;

endmodule

// File: tb/tb_mem_sram_ctrl.sv
// Directed bench for mem_sram_ctrl with a behavioural SRAM read model and write-pulse log.
module tb_mem_sram_ctrl;

  logic        MCLK = 1'b0;
  logic        MRESETn;
  logic        MEN;
  logic [3:0]  MWE;
  logic [20:0] MADDR;
  logic [31:0] MDIN;
  logic        MDONE, MERROR;
  logic [31:0] MDOUT;
  logic [18:0] SADDR;
  logic [15:0] SDQ_O, SDQ_I;
  logic        SDQ_OE, SCE_N, SOE_N, SWE_N, SLB_N, SUB_N;

  int passed = 0;
  int total  = 0;

  always #5 MCLK = ~MCLK;

  mem_sram_ctrl #(
    .DATA_WIDTH (32),
    .MEM_BYTES  (1048576),
    .WAIT_CYCLES(2)
  ) dut (
    .MCLK   (MCLK),
    .MRESETn(MRESETn),
    .MEN    (MEN),
    .MWE    (MWE),
    .MADDR  (MADDR),
    .MDIN   (MDIN),
    .MDONE  (MDONE),
    .MERROR (MERROR),
    .MDOUT  (MDOUT),
    .SADDR  (SADDR),
    .SDQ_O  (SDQ_O),
    .SDQ_I  (SDQ_I),
    .SDQ_OE (SDQ_OE),
    .SCE_N  (SCE_N),
    .SOE_N  (SOE_N),
    .SWE_N  (SWE_N),
    .SLB_N  (SLB_N),
    .SUB_N  (SUB_N)
  );

  function automatic logic [15:0] rom(input logic [18:0] a);
    case (a)
      19'h80:  return 16'h1234;
      19'h81:  return 16'hABCD;
      default: return {a[7:0], 8'h5A};
    endcase
  endfunction

  assign SDQ_I = (!SCE_N && !SOE_N) ? rom(SADDR) : 16'h0000;

  // Activity monitor: cycle counters plus one log entry per SWE_N low pulse.
  int          sce_cnt = 0, done_cnt = 0, overlap_cnt = 0, oe_bad = 0;
  logic [18:0] wq_addr[$];
  logic [15:0] wq_data[$];
  logic [2:0]  wq_ctl[$];
  int          wq_len[$];
  logic        in_pulse = 1'b0;
  int          cur_len = 0;

  always @(negedge MCLK) begin
    if (!SCE_N) sce_cnt <= sce_cnt + 1;
    if (MDONE) done_cnt <= done_cnt + 1;
    if (!SWE_N && !SOE_N) overlap_cnt <= overlap_cnt + 1;
    if (SDQ_OE && (!SOE_N || SCE_N)) oe_bad <= oe_bad + 1;
    if (!SWE_N) begin
      if (!in_pulse) begin
        wq_addr.push_back(SADDR);
        wq_data.push_back(SDQ_O);
        wq_ctl.push_back({SDQ_OE, SLB_N, SUB_N});
        in_pulse <= 1'b1;
        cur_len  <= 1;
      end else begin
        cur_len <= cur_len + 1;
      end
    end else if (in_pulse) begin
      wq_len.push_back(cur_len);
      in_pulse <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("%s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [4:0] strobes();
    return {SCE_N, SOE_N, SWE_N, SLB_N, SUB_N};
  endfunction

  // Issues one request; lat = clock edges from capture edge until MDONE is seen.
  task automatic do_req(input logic [3:0] we, input logic [20:0] addr, input logic [31:0] din,
                        input int glitch, output int lat, output logic err, output logic [31:0] dout);
    @(negedge MCLK);
    MEN = 1'b1; MWE = we; MADDR = addr; MDIN = din;
    @(negedge MCLK);
    MEN = 1'b0;
    lat = 0;
    while (!MDONE && lat < 40) begin
      @(posedge MCLK);
      lat++;
      @(negedge MCLK);
      if (lat == glitch) begin
        MEN = 1'b1; MWE = 4'hF; MADDR = 21'h40; MDIN = 32'h5555_5555;
      end else begin
        MEN = 1'b0;
      end
    end
    err  = MERROR;
    dout = MDOUT;
    #1;
  endtask

  initial begin
    int          lat, base, sce0, done0;
    logic        err;
    logic [31:0] dout;

    // Reset with MEN held high
    MRESETn = 1'b0; MEN = 1'b1; MWE = 4'h0; MADDR = 21'h100; MDIN = 32'h0;
    repeat (3) @(negedge MCLK);
    chk("rst_strobes", 32'(strobes()), 32'h1F);
    chk("rst_mdone", 32'(MDONE), 32'h0);
    chk("rst_mdout", MDOUT, 32'h0);
    chk("rst_oe_saddr", {12'h0, SDQ_OE, SADDR}, 32'h0);
    MEN = 1'b0;
    MRESETn = 1'b1;

    // Full read from 0x100
    base = wq_addr.size(); sce0 = sce_cnt;
    do_req(4'b0000, 21'h100, 32'h0, 0, lat, err, dout);
    chk("rd_lat", 32'(lat), 32'd10);
    chk("rd_err", 32'(err), 32'h0);
    chk("rd_data", dout, 32'hABCD_1234);
    chk("rd_no_swe", 32'(wq_addr.size() - base), 32'd0);
    chk("rd_sce_cycles", 32'(sce_cnt - sce0), 32'd10);

    // Full-word write
    base = wq_addr.size();
    do_req(4'b1111, 21'h8, 32'hDEAD_BEEF, 0, lat, err, dout);
    chk("wr_lat", 32'(lat), 32'd10);
    chk("wr_err", 32'(err), 32'h0);
    chk("wr_pulses", 32'(wq_addr.size() - base), 32'd2);
    if (wq_len.size() >= base + 2) begin
      chk("wr0_addr", 32'(wq_addr[base]), 32'h4);
      chk("wr0_data", 32'(wq_data[base]), 32'hBEEF);
      chk("wr0_ctl", 32'(wq_ctl[base]), 32'b100);
      chk("wr0_len", 32'(wq_len[base]), 32'd3);
      chk("wr1_addr", 32'(wq_addr[base+1]), 32'h5);
      chk("wr1_data", 32'(wq_data[base+1]), 32'hDEAD);
      chk("wr1_ctl", 32'(wq_ctl[base+1]), 32'b100);
      chk("wr1_len", 32'(wq_len[base+1]), 32'd3);
    end
    chk("wr_mdout_kept", dout, 32'hABCD_1234);

    // Single-lane write, upper half only
    base = wq_addr.size(); sce0 = sce_cnt;
    do_req(4'b0100, 21'h10, 32'h1122_3344, 0, lat, err, dout);
    chk("hw_lat", 32'(lat), 32'd5);
    chk("hw_pulses", 32'(wq_addr.size() - base), 32'd1);
    chk("hw_sce_cycles", 32'(sce_cnt - sce0), 32'd5);
    if (wq_len.size() >= base + 1) begin
      chk("hw_addr", 32'(wq_addr[base]), 32'h9);
      chk("hw_data", 32'(wq_data[base]), 32'h1122);
      chk("hw_ctl", 32'(wq_ctl[base]), 32'b101);
      chk("hw_len", 32'(wq_len[base]), 32'd3);
    end

    // Out-of-range request
    sce0 = sce_cnt;
    do_req(4'b0000, 21'h10_0000, 32'h0, 0, lat, err, dout);
    chk("oor_lat", 32'(lat), 32'd0);
    chk("oor_err", 32'(err), 32'h1);
    chk("oor_mdout", dout, 32'hABCD_1234);
    chk("oor_no_sce", 32'(sce_cnt - sce0), 32'd0);

    // Write with a stray MEN pulse mid-operation
    base = wq_addr.size(); done0 = done_cnt;
    do_req(4'b1111, 21'h20, 32'hCAFE_F00D, 3, lat, err, dout);
    chk("gl_lat", 32'(lat), 32'd10);
    chk("gl_pulses", 32'(wq_addr.size() - base), 32'd2);
    if (wq_len.size() >= base + 2) begin
      chk("gl0_addr", 32'(wq_addr[base]), 32'h10);
      chk("gl0_data", 32'(wq_data[base]), 32'hF00D);
      chk("gl1_addr", 32'(wq_addr[base+1]), 32'h11);
      chk("gl1_data", 32'(wq_data[base+1]), 32'hCAFE);
    end
    sce0 = sce_cnt;
    repeat (12) @(negedge MCLK);
    #1;
    chk("gl_no_extra_sce", 32'(sce_cnt - sce0), 32'd0);
    chk("gl_one_done", 32'(done_cnt - done0), 32'd1);

    // Reset during ACCESS of a read
    @(negedge MCLK);
    MEN = 1'b1; MWE = 4'b0000; MADDR = 21'h100;
    @(negedge MCLK);
    MEN = 1'b0;
    @(negedge MCLK);
    chk("ra_in_access", 32'(SOE_N), 32'h0);
    done0 = done_cnt;
    MRESETn = 1'b0;
    @(negedge MCLK);
    chk("ra_strobes", 32'(strobes()), 32'h1F);
    chk("ra_mdone", 32'(MDONE), 32'h0);
    chk("ra_mdout", MDOUT, 32'h0);
    @(negedge MCLK);
    MRESETn = 1'b1;
    sce0 = sce_cnt;
    repeat (12) @(negedge MCLK);
    #1;
    chk("ra_no_done", 32'(done_cnt - done0), 32'd0);
    chk("ra_no_sce", 32'(sce_cnt - sce0), 32'd0);

    chk("no_we_oe_overlap", 32'(overlap_cnt), 32'd0);
    chk("no_oe_on_read_idle", 32'(oe_bad), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
